// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner: per-slot prescaler, blanking, double-buffered digit data.
// Optional blink feature under `SEG_BLINK_EN` (adds Blink_Mask and BLINK_FRAMES).
module seg_scan_display #(
  parameter int DIGITS    = 2,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
`ifdef SEG_BLINK_EN
  , parameter int BLINK_FRAMES = 25
`endif
) (
  input  logic                  Sys_CLK,
  input  logic                  Sys_RST,
  input  logic [4*DIGITS-1:0]   Data_In,
  input  logic [DIGITS-1:0]     DP_In,
  input  logic                  Load,
  input  logic [DIGITS-1:0]     Digit_EN,
`ifdef SEG_BLINK_EN
  input  logic [DIGITS-1:0]     Blink_Mask,
`endif
  output logic [DIGITS-1:0]     COM,
  output logic [7:0]            SEG,
  output logic                  Frame_Done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shadow_data;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] disp_data;
  logic [DIGITS-1:0]   disp_dp;
  logic                pending;

  logic                tick;
  logic                wrap;
  logic                blink_ok;
  logic [3:0]          nib;
  logic                dp_cur;
  logic [6:0]          glyph;
  logic [DIGITS-1:0]   com_next;

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt;
  logic          blink_off;

  always_ff @(posedge Sys_CLK) begin
    if (!Sys_RST) begin
      frame_cnt <= '0;
      blink_off <= 1'b0;
    end else if (wrap) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    tick     = (cnt == CNT_LAST);
    wrap     = tick && (idx == IDX_LAST);
    nib      = disp_data[{idx, 2'b00} +: 4];
    dp_cur   = disp_dp[idx];
`ifdef SEG_BLINK_EN
    blink_ok = !(blink_off && Blink_Mask[idx]);
`else
    blink_ok = 1'b1;
`endif
    // Glyphs are active-low, bit 0 = segment a.
    case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
    com_next = '1;
    if ((cnt >= BLANK_END) && Digit_EN[idx] && blink_ok)
      com_next[idx] = 1'b0;
  end

  always_ff @(posedge Sys_CLK) begin
    if (!Sys_RST) begin
      cnt         <= '0;
      idx         <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      disp_data   <= '0;
      disp_dp     <= '0;
      pending     <= 1'b0;
      COM         <= '1;
      SEG         <= '1;
      Frame_Done  <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      // A Load coinciding with the wrap bypasses the shadow so it is never a frame late.
      if (wrap) begin
        if (Load) begin
          shadow_data <= Data_In;
          shadow_dp   <= DP_In;
          disp_data   <= Data_In;
          disp_dp     <= DP_In;
          pending     <= 1'b0;
        end else if (pending) begin
          disp_data   <= shadow_data;
          disp_dp     <= shadow_dp;
          pending     <= 1'b0;
        end
      end else if (Load) begin
        shadow_data <= Data_In;
        shadow_dp   <= DP_In;
        pending     <= 1'b1;
      end

      COM        <= com_next;
      SEG        <= {~dp_cur, glyph};
      Frame_Done <= wrap;
    end
  end

endmodule
